dac_spi_rx: RTL and testbench
=============================

# dac_spi_rx

Frame receiver for the DAC serial lanes: samples each lane's SYNC/SCLK/DIN triple in the `dataclk` domain, deserializes 24-bit DAC frames (8 control bits + 16 data bits, MSB first), and presents each completed frame as a parallel word with a one-cycle valid strobe. It is the receiving end of the `DAC_SYNC`/`DAC_SCLK`/`DAC_DIN` buses driven by the main DAC output path. It provides closed-loop checking of DAC output words in simulation and on the board's loopback header.

## Interface
Parameters
- `LANES`, 8: number of independent DAC lanes.
- `FRAME_BITS`, 24: bits per frame; data is always the last 16 bits, control the first `FRAME_BITS-16`.

Ports
- `dataclk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `DAC_SYNC`  in  LANES  frame select per lane, active low, asynchronous to `dataclk`.
- `DAC_SCLK`  in  LANES  serial clock per lane; data sampled on falling edge.
- `DAC_DIN`  in  LANES  serial data per lane.
- `rx_data`  out  16*LANES  last received data word; lane k at [16k+15:16k].
- `rx_ctrl`  out  8*LANES  last received control byte; lane k at [8k+7:8k].
- `rx_valid`  out  LANES  one-cycle strobe: lane k frame completed.
- `rx_err`  out  LANES  one-cycle strobe: lane k frame aborted or overrun.
- `rx_frame_count`  out  16*LANES  per-lane count of valid frames, wraps 0xFFFF→0.

## Operation
- Inputs pass through 2-flop synchronizers plus one history flop per signal. Edge detects use synchronized vs. history (`s2`/`s3`). DIN is sampled from the same synchronizer stage as SCLK so alignment is preserved.
- Per-lane FSM, 5-bit bit counter, `FRAME_BITS` shift register:
  - ARM: entered at reset. Waits for synchronized SYNC high, then goes to IDLE. A lane held low through reset never produces a partial frame.
  - IDLE: on SYNC falling edge, clear counter and go to SHIFT.
  - SHIFT: on each SCLK falling edge, shift DIN in at LSB and increment counter.
    - On the edge where counter reaches `FRAME_BITS`: latch `rx_ctrl`/`rx_data`, pulse `rx_valid`, increment `rx_frame_count`, go to DONE.
    - SYNC rising with counter < `FRAME_BITS`: pulse `rx_err`, outputs unchanged, go to IDLE.
  - DONE: SYNC rising → IDLE. Any further SCLK falling edge → pulse `rx_err` once, stay in DONE. Latched word is kept.
- Simultaneous SYNC rise and final SCLK fall in the same cycle: the frame completes (valid). Next cycle goes to IDLE with no error.
- Simultaneous SYNC fall and SCLK fall: the SYNC edge wins. The SCLK edge is not counted.
- Lanes are fully independent; any combination may strobe in the same cycle.

## Timing
- Reset values: `rx_data`=0, `rx_ctrl`=0, `rx_valid`=0, `rx_err`=0, `rx_frame_count`=0, all FSMs in ARM, synchronizers cleared to 1 (idle-high SYNC/SCLK).
- Input constraint: SCLK high and low phases ≥ 2 `dataclk` cycles each; DIN stable ≥ 2 cycles around the SCLK fall; SYNC high ≥ 2 cycles between frames. Violations are undefined, but the FSM must never lock up.
- Latency: `rx_valid`/`rx_err` assert on the 3rd `dataclk` rising edge after the first edge that samples the raw triggering pin change. `rx_data`/`rx_ctrl` update on the same edge as `rx_valid`.
- `rx_frame_count` updates on the same edge as `rx_valid`.
- Strobes are exactly one cycle wide.
- Reset assertion mid-frame forces ARM immediately and discards the partial frame.

## Configuration
- `DAC_RX_CTRL_CHECK_EN` defined: a completed frame whose `ctrl[1:0]` (power-down bits) ≠ 2'b00 is treated as an error.
  - `rx_err` pulses instead of `rx_valid`.
  - `rx_data`, `rx_ctrl` and `rx_frame_count` are not updated.
- Undefined: the control byte is captured unconditionally and never generates an error.

## Test plan
- Lane 0, frame ctrl=0x00, data=0x8000, SCLK half-period 4 cycles → `rx_valid[0]` one pulse 3 cycles after the 24th SCLK fall; `rx_data[15:0]`=0x8000; `rx_frame_count[15:0]`=1; other lanes idle.
- Lane 3 aborted after 10 bits by SYNC rise → one `rx_err[3]` pulse; `rx_data[63:48]` unchanged. The next full frame with data=0x1234 → valid, data 0x1234.
- Lane 5, 25 SCLK falls within one SYNC low → `rx_valid[5]` once with the first-24-bit word, then `rx_err[5]` once.
- All 8 lanes, simultaneous frames with data=0x0101·(k+1) → all `rx_valid` bits high in the same cycle with correct per-lane words.
- Reset released while `DAC_SYNC[1]`=0 mid-frame → no strobes on lane 1 until SYNC goes high; the following complete frame is received normally. Reset pulsed mid-frame on lane 2 → no strobe for the partial frame.
- With `DAC_RX_CTRL_CHECK_EN`: frame ctrl=0x01, data=0xFFFF → `rx_err` pulse, `rx_data` holds the previous value, count unchanged. Without the macro → valid with `rx_ctrl`=0x01, `rx_data`=0xFFFF.

Source files
------------

// File: rtl/dac_spi_rx.sv
// dac_spi_rx: per-lane SPI frame receiver for the DAC_SYNC/DAC_SCLK/DAC_DIN loopback buses.
//
// Parameters
//   LANES       number of independent DAC lanes
//   FRAME_BITS  bits per frame; last 16 are data, the leading FRAME_BITS-16 are control
// Ports
//   dataclk         system clock, rising edge
//   reset_n         asynchronous active-low reset
//   DAC_SYNC        per-lane frame select, active low, asynchronous
//   DAC_SCLK        per-lane serial clock, data taken on its falling edge
//   DAC_DIN         per-lane serial data, MSB first
//   rx_data         last data word per lane, lane k at [16k+15:16k]
//   rx_ctrl         last control byte per lane, lane k at [8k+7:8k]
//   rx_valid        one-cycle strobe per lane: frame completed
//   rx_err          one-cycle strobe per lane: frame aborted or overrun
//   rx_frame_count  per-lane count of valid frames, wrapping
// Configuration
//   DAC_RX_CTRL_CHECK_EN  when defined, a completed frame with nonzero ctrl[1:0]
//                         (power-down bits) is reported on rx_err and not latched
module dac_spi_rx #(
    parameter int LANES      = 8,
    parameter int FRAME_BITS = 24
) (
    input  logic                  dataclk,
    input  logic                  reset_n,
    input  logic [LANES-1:0]      DAC_SYNC,
    input  logic [LANES-1:0]      DAC_SCLK,
    input  logic [LANES-1:0]      DAC_DIN,
    output logic [16*LANES-1:0]   rx_data,
    output logic [8*LANES-1:0]    rx_ctrl,
    output logic [LANES-1:0]      rx_valid,
    output logic [LANES-1:0]      rx_err,
    output logic [16*LANES-1:0]   rx_frame_count
);
    typedef enum logic [1:0] {ARM, IDLE, SHIFT, DONE} state_t;

    logic [LANES-1:0] r_sync_s1, r_sync_s2, r_sync_s3;
    logic [LANES-1:0] r_sclk_s1, r_sclk_s2, r_sclk_s3;
    logic [LANES-1:0] r_din_s1, r_din_s2;
    logic [1:0]       r_warm;
    logic [LANES-1:0] w_sync_fall, w_sync_rise, w_sclk_fall;

    // Synchronizers reset to idle-high so no edges appear out of reset.
    // r_warm marks when s2 holds a real pin sample rather than the reset value,
    // so ARM does not mistake the reset-forced high for a released SYNC.
    always_ff @(posedge dataclk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync_s1 <= '1;
            r_sync_s2 <= '1;
            r_sync_s3 <= '1;
            r_sclk_s1 <= '1;
            r_sclk_s2 <= '1;
            r_sclk_s3 <= '1;
            r_din_s1  <= '1;
            r_din_s2  <= '1;
            r_warm    <= '0;
        end else begin
            r_sync_s1 <= DAC_SYNC;
            r_sync_s2 <= r_sync_s1;
            r_sync_s3 <= r_sync_s2;
            r_sclk_s1 <= DAC_SCLK;
            r_sclk_s2 <= r_sclk_s1;
            r_sclk_s3 <= r_sclk_s2;
            r_din_s1  <= DAC_DIN;
            r_din_s2  <= r_din_s1;
            r_warm    <= {r_warm[0], 1'b1};
        end
    end

    assign w_sync_fall = r_sync_s3 & ~r_sync_s2;
    assign w_sync_rise = ~r_sync_s3 & r_sync_s2;
    assign w_sclk_fall = r_sclk_s3 & ~r_sclk_s2;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        state_t                r_state;
        logic [4:0]            r_cnt;
        logic [FRAME_BITS-2:0] r_shift;
        logic [15:0]           r_data;
        logic [7:0]            r_ctrl;
        logic [15:0]           r_count;
        logic                  r_valid;
        logic                  r_err;
        logic [FRAME_BITS-1:0] w_frame;
        logic                  w_last;
        logic                  w_bad;

        // Full frame as it stands after the bit arriving this cycle.
        assign w_frame = {r_shift, r_din_s2[k]};
        assign w_last  = w_sclk_fall[k] && r_cnt == 5'(FRAME_BITS - 1);
`ifdef DAC_RX_CTRL_CHECK_EN
        assign w_bad   = |w_frame[17:16];
`else
        assign w_bad   = 1'b0;
`endif

        always_ff @(posedge dataclk or negedge reset_n) begin
            if (!reset_n) begin
                r_state <= ARM;
                r_cnt   <= '0;
                r_shift <= '0;
                r_data  <= '0;
                r_ctrl  <= '0;
                r_count <= '0;
                r_valid <= 1'b0;
                r_err   <= 1'b0;
            end else begin
                r_valid <= 1'b0;
                r_err   <= 1'b0;
                case (r_state)
                    ARM: begin
                        if (r_warm[1] && r_sync_s2[k])
                            r_state <= IDLE;
                    end
                    IDLE: begin
                        // A coincident SCLK fall is deliberately not counted.
                        if (w_sync_fall[k]) begin
                            r_cnt   <= '0;
                            r_state <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        // Final bit takes priority over a coincident SYNC rise.
                        if (w_last) begin
                            r_shift <= w_frame[FRAME_BITS-2:0];
                            r_cnt   <= r_cnt + 5'd1;
                            r_state <= DONE;
                            if (w_bad) begin
                                r_err <= 1'b1;
                            end else begin
                                r_valid <= 1'b1;
                                r_data  <= w_frame[15:0];
                                r_ctrl  <= 8'(w_frame[FRAME_BITS-1:16]);
                                r_count <= r_count + 16'd1;
                            end
                        end else if (w_sync_rise[k]) begin
                            r_err   <= 1'b1;
                            r_state <= IDLE;
                        end else if (w_sclk_fall[k]) begin
                            r_shift <= w_frame[FRAME_BITS-2:0];
                            r_cnt   <= r_cnt + 5'd1;
                        end
                    end
                    DONE: begin
                        // Level check also covers a SYNC rise consumed in the completing cycle.
                        if (r_sync_s2[k])
                            r_state <= IDLE;
                        else if (w_sclk_fall[k])
                            r_err <= 1'b1;
                    end
                    default: r_state <= ARM;
                endcase
            end
        end

        assign rx_data[16*k +: 16]        = r_data;
        assign rx_ctrl[8*k +: 8]          = r_ctrl;
        assign rx_frame_count[16*k +: 16] = r_count;
        assign rx_valid[k]                = r_valid;
        assign rx_err[k]                  = r_err;
    end
endmodule

// File: tb/tb_dac_spi_rx.sv
// tb_dac_spi_rx: scoreboard bench for dac_spi_rx with directed frames.
module tb_dac_spi_rx;
    localparam int L = 8;

    typedef struct {
        int          lane;
        bit          is_err;
        int          at;
        logic [15:0] data;
        logic [7:0]  ctrl;
        logic [15:0] cnt;
    } exp_t;

    logic              dataclk = 1'b0;
    logic              reset_n = 1'b0;
    logic [L-1:0]      sync_v  = '1;
    logic [L-1:0]      sclk_v  = '1;
    logic [L-1:0]      din_v   = '0;
    logic [16*L-1:0]   rx_data;
    logic [8*L-1:0]    rx_ctrl;
    logic [L-1:0]      rx_valid;
    logic [L-1:0]      rx_err;
    logic [16*L-1:0]   rx_frame_count;

    dac_spi_rx #(.LANES(L), .FRAME_BITS(24)) dut (
        .dataclk        (dataclk),
        .reset_n        (reset_n),
        .DAC_SYNC       (sync_v),
        .DAC_SCLK       (sclk_v),
        .DAC_DIN        (din_v),
        .rx_data        (rx_data),
        .rx_ctrl        (rx_ctrl),
        .rx_valid       (rx_valid),
        .rx_err         (rx_err),
        .rx_frame_count (rx_frame_count)
    );

    always #5 dataclk = ~dataclk;

    int cyc = 0;
    always @(posedge dataclk) cyc <= cyc + 1;

    exp_t        q[$];
    logic [23:0] fw[L];
    logic [15:0] m_data[L];
    logic [7:0]  m_ctrl[L];
    logic [15:0] m_cnt[L];
    int          checks = 0;
    int          fails = 0;
    int          bi = 0;
    bit          expect_on = 1'b1;
    int          half = 4;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge dataclk);
    endtask

    function automatic bit ctrl_bad(input int k);
`ifdef DAC_RX_CTRL_CHECK_EN
        return fw[k][17:16] != 2'b00;
`else
        return 1'b0 && (k < 0);
`endif
    endfunction

    task automatic push(input int k, input bit err);
        exp_t e;
        if (!err) begin
            m_data[k] = fw[k][15:0];
            m_ctrl[k] = fw[k][23:16];
            m_cnt[k]  = m_cnt[k] + 16'd1;
        end
        e.lane   = k;
        e.is_err = err;
        e.at     = cyc + 3;
        e.data   = m_data[k];
        e.ctrl   = m_ctrl[k];
        e.cnt    = m_cnt[k];
        q.push_back(e);
    endtask

    task automatic model_reset();
        for (int k = 0; k < L; k++) begin
            m_data[k] = '0;
            m_ctrl[k] = '0;
            m_cnt[k]  = '0;
        end
    endtask

    task automatic start(input logic [L-1:0] m);
        bi = 0;
        sync_v = sync_v & ~m;
        wait_cyc(2 * half);
    endtask

    task automatic bits(input logic [L-1:0] m, input int n);
        repeat (n) begin
            for (int k = 0; k < L; k++)
                if (m[k]) din_v[k] = (bi < 24) ? fw[k][23-bi] : 1'b0;
            wait_cyc(half);
            sclk_v = sclk_v & ~m;
            if (expect_on)
                for (int k = 0; k < L; k++)
                    if (m[k]) begin
                        if (bi == 23) push(k, ctrl_bad(k));
                        else if (bi >= 24) push(k, 1'b1);
                    end
            bi++;
            wait_cyc(half);
            sclk_v = sclk_v | m;
        end
    endtask

    task automatic stop(input logic [L-1:0] m);
        wait_cyc(2);
        sync_v = sync_v | m;
        if (expect_on && bi < 24)
            for (int k = 0; k < L; k++)
                if (m[k]) push(k, 1'b1);
        wait_cyc(6);
    endtask

    task automatic frame(input logic [L-1:0] m, input int n);
        start(m);
        bits(m, n);
        stop(m);
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        wait_cyc(3);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic check_zero(input string tag);
        check({tag, " rx_data"}, 32'(rx_data == '0), 32'd1);
        check({tag, " rx_ctrl"}, 32'(rx_ctrl == '0), 32'd1);
        check({tag, " rx_valid"}, 32'(rx_valid), 32'd0);
        check({tag, " rx_err"}, 32'(rx_err), 32'd0);
        check({tag, " rx_frame_count"}, 32'(rx_frame_count == '0), 32'd1);
    endtask

    // Monitor: every strobe must match the oldest pending expectation for its lane.
    int   idx;
    exp_t e;
    always @(negedge dataclk) begin
        for (int k = 0; k < L; k++)
            if (rx_valid[k] || rx_err[k]) begin
                idx = -1;
                for (int i = 0; i < q.size(); i++)
                    if (idx < 0 && q[i].lane == k) idx = i;
                if (idx < 0) begin
                    check($sformatf("unexpected strobe lane %0d {valid,err}", k),
                          32'({rx_valid[k], rx_err[k]}), 32'd0);
                end else begin
                    e = q[idx];
                    q.delete(idx);
                    check($sformatf("lane %0d strobe kind {valid,err}", k),
                          32'({rx_valid[k], rx_err[k]}), e.is_err ? 32'd1 : 32'd2);
                    check($sformatf("lane %0d strobe cycle", k), 32'(cyc), 32'(e.at));
                    check($sformatf("lane %0d rx_data", k), 32'(rx_data[16*k +: 16]), 32'(e.data));
                    check($sformatf("lane %0d rx_ctrl", k), 32'(rx_ctrl[8*k +: 8]), 32'(e.ctrl));
                    check($sformatf("lane %0d rx_frame_count", k),
                          32'(rx_frame_count[16*k +: 16]), 32'(e.cnt));
                end
            end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        for (int k = 0; k < L; k++) fw[k] = '0;
        wait_cyc(4);
        check_zero("in reset");
        reset_n = 1'b1;
        wait_cyc(1);
        check_zero("after reset");
        wait_cyc(5);

        fw[0] = 24'h008000;
        frame(8'h01, 24);

        fw[3] = 24'h00F0F0;
        frame(8'h08, 10);
        fw[3] = 24'h001234;
        frame(8'h08, 24);

        fw[5] = 24'h00ABCD;
        frame(8'h20, 25);

        for (int k = 0; k < L; k++) fw[k] = {6'(k), 2'b00, 16'h0101 * 16'(k + 1)};
        frame(8'hFF, 24);

        fw[0] = 24'h01FFFF;
        frame(8'h01, 24);

        wait_cyc(10);
        check("queue drained before reset tests", 32'(q.size()), 32'd0);

        expect_on = 1'b0;
        fw[1] = 24'h00C3C3;
        start(8'h02);
        bits(8'h02, 5);
        pulse_reset();
        bits(8'h02, 5);
        wait_cyc(2);
        sync_v[1] = 1'b1;
        wait_cyc(6);
        expect_on = 1'b1;
        check_zero("after lane1 reset");
        fw[1] = 24'h005A5A;
        frame(8'h02, 24);

        expect_on = 1'b0;
        fw[2] = 24'h007777;
        start(8'h04);
        bits(8'h04, 10);
        pulse_reset();
        bits(8'h04, 14);
        stop(8'h04);
        expect_on = 1'b1;
        fw[2] = 24'h00BEEF;
        frame(8'h04, 24);

        wait_cyc(20);
        check("pending expectations", 32'(q.size()), 32'd0);
        for (int k = 0; k < L; k++) begin
            check($sformatf("final lane %0d rx_frame_count", k), 32'(rx_frame_count[16*k +: 16]), 32'(m_cnt[k]));
            check($sformatf("final lane %0d rx_data", k), 32'(rx_data[16*k +: 16]), 32'(m_data[k]));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
